// File: rtl/frame_burst_sched_pkg.sv
// Shared types and defaults for the VDMA frame burst scheduler.
package frame_burst_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StStep,
    StSettle,
    StFend
  } fbs_state_e;

  // Full burst length shared with the address generator's burst map derivation.
  localparam int unsigned BurstLenDefault = 64;

  // Number of cycles held in SETTLE so the address generator's edge detect catches up.
  localparam int unsigned SettleCycles = 2;

endpackage : frame_burst_sched_pkg

// File: rtl/frame_burst_sched.sv
// Sequences one video frame of AXI bursts: full bursts plus an optional tail per line,
// with frame buffers rotating round-robin across NBUF bases.
module frame_burst_sched
  import frame_burst_sched_pkg::*;
#(
  parameter int unsigned ASIZE     = 29,
  parameter int unsigned NBUF      = 3,
  parameter int unsigned LCNT_W    = 12,
  parameter int unsigned BCNT_W    = 8,
  parameter int unsigned BURST_LEN = BurstLenDefault,
  parameter int unsigned LEN_W     = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic [ASIZE-1:0]  base0,
  input  logic [ASIZE-1:0]  base1,
  input  logic [ASIZE-1:0]  base2,
  input  logic [ASIZE-1:0]  base3,
  input  logic [LCNT_W-1:0] lines,
  input  logic [BCNT_W-1:0] full_bursts,
  input  logic [LEN_W-1:0]  tail_len,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_done,
  output logic              new_base,
  output logic [ASIZE-1:0]  baseaddr,
  output logic              burst_done,
  output logic              tail_done,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        cur_buf
);

  localparam logic [LEN_W-1:0] FullLen  = LEN_W'(BURST_LEN);
  localparam logic [1:0]       LastBuf  = 2'(NBUF - 1);
  localparam logic             SettleLast = 1'(SettleCycles - 1);

  fbs_state_e        state_q, state_d;
  logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic              settle_q, settle_d;
  logic [1:0]        cur_buf_q, cur_buf_d;
  logic [ASIZE-1:0]  base_q, base_d;
  logic [ASIZE-1:0]  base_sel;
  logic              is_tail;
  logic              line_end;
  logic              start_ok;

  // Select the base of the buffer about to be written.
  always_comb begin
    unique case (cur_buf_q)
      2'd0:    base_sel = base0;
      2'd1:    base_sel = base1;
      2'd2:    base_sel = base2;
      default: base_sel = base3;
    endcase
  end

  // Burst classification: once all full bursts are out, the current one is the tail.
  // A last full burst with no tail closes the line itself.
  always_comb begin
    is_tail  = (burst_cnt_q >= full_bursts);
    line_end = is_tail ||
               (({1'b0, burst_cnt_q} + 1'b1) == {1'b0, full_bursts} && tail_len == '0);
    start_ok = frame_start && enable && (lines != '0) &&
               ((full_bursts != '0) || (tail_len != '0));
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      line_cnt_q  <= '0;
      burst_cnt_q <= '0;
      settle_q    <= 1'b0;
      cur_buf_q   <= '0;
      base_q      <= '0;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      settle_q    <= settle_d;
      cur_buf_q   <= cur_buf_d;
      base_q      <= base_d;
    end
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    burst_cnt_d = burst_cnt_q;
    settle_d    = settle_q;
    cur_buf_d   = cur_buf_q;
    base_d      = base_q;
    cmd_valid   = 1'b0;
    cmd_len     = '0;
    new_base    = 1'b0;
    burst_done  = 1'b0;
    tail_done   = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          base_d  = base_sel;
          state_d = StLoad;
        end
      end
      StLoad: begin
        new_base    = 1'b1;
        busy        = 1'b1;
        line_cnt_d  = '0;
        burst_cnt_d = '0;
        state_d     = StIssue;
      end
      StIssue: begin
        busy      = 1'b1;
        cmd_valid = 1'b1;
        cmd_len   = is_tail ? tail_len : FullLen;
        if (cmd_ready) state_d = StWait;
      end
      StWait: begin
        busy = 1'b1;
        if (cmd_done) state_d = StStep;
      end
      StStep: begin
        busy     = 1'b1;
        settle_d = 1'b0;
        if (line_end) begin
          tail_done   = 1'b1;
          burst_cnt_d = '0;
          if (line_cnt_q != lines) line_cnt_d = line_cnt_q + 1'b1;
        end else begin
          burst_done  = 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        state_d = StSettle;
      end
      StSettle: begin
        busy     = 1'b1;
        settle_d = 1'b1;
        if (settle_q == SettleLast) begin
          if (line_cnt_q == lines) state_d = StFend;
          else if (!enable)        state_d = StIdle;
          else                     state_d = StIssue;
        end
      end
      StFend: begin
        frame_done = 1'b1;
        cur_buf_d  = (cur_buf_q == LastBuf) ? 2'd0 : cur_buf_q + 2'd1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign baseaddr = base_q;
  assign cur_buf  = cur_buf_q;

endmodule : frame_burst_sched
